// File: rtl/axi_lite_master_txn.sv
// axi_lite_master_txn: AXI4-Lite master traffic generator.
// A rising edge on init runs NUM_TXN single-beat writes to consecutive words,
// then reads the same words back and compares them on the fly. txn_done pulses
// for one cycle when the sequence ends; error is a sticky mismatch / non-OKAY flag
// that is cleared at the next start.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   init                   start request (level, rising edge detected)
//   error, txn_done        sticky failure flag, one-cycle completion pulse
//   aw*/w*/b*/ar*/r*       AXI4-Lite master interface (6-bit address, 32-bit data)
//
// Configuration macro:
//   AXIL_TIMEOUT_EN        adds a handshake watchdog that aborts a stalled sequence
module axi_lite_master_txn #(
  parameter int unsigned NUM_TXN   = 4,
  parameter logic [5:0]  BASE_ADDR = 6'h00,
  parameter logic [31:0] DATA_SEED = 32'hA5A5_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  output logic        error,
  output logic        txn_done,
  output logic [5:0]  awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [5:0]  araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t        state;
  logic          init_q;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;

  // Word index -> byte address / expected data (6-bit address wrap, 32-bit data wrap)
  function automatic logic [AW-1:0] word_addr(input logic [CW-1:0] idx);
    return BASE_ADDR + AW'({idx, 2'b00});
  endfunction

  function automatic logic [DW-1:0] word_data(input logic [CW-1:0] idx);
    return DATA_SEED + DW'(idx);
  endfunction

  logic          start;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          aw_fin, w_fin;
  logic          last_w, last_r;
  logic [CW-1:0] wcnt_nxt, rcnt_nxt;
  logic          timeout;

  assign start  = init && !init_q;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  // A channel is finished once its valid has dropped or it handshakes this cycle
  assign aw_fin = !awvalid || awready;
  assign w_fin  = !wvalid || wready;
  assign last_w = (wcnt == CW'(NUM_TXN - 1));
  assign last_r = (rcnt == CW'(NUM_TXN - 1));
  assign wcnt_nxt = last_w ? '0 : wcnt + CW'(1);
  assign rcnt_nxt = last_r ? '0 : rcnt + CW'(1);

`ifdef AXIL_TIMEOUT_EN
  localparam int unsigned TOW = 16;
  // Counter holds edges elapsed since the last handshake; abort fires on the 1023rd
  localparam logic [TOW-1:0] TO_LAST = TOW'(1022);

  logic [TOW-1:0] wdog;

  // Watchdog: reloaded on any handshake, parked while idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog <= '0;
    end else if (state == IDLE || aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + TOW'(1);
    end
  end

  assign timeout = (state != IDLE) && (wdog == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Sequencer: one outstanding transaction, all bus outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      init_q   <= 1'b0;
      wcnt     <= '0;
      rcnt     <= '0;
      error    <= 1'b0;
      txn_done <= 1'b0;
      awaddr   <= '0;
      awprot   <= '0;
      awvalid  <= 1'b0;
      wdata    <= '0;
      wstrb    <= '0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      araddr   <= '0;
      arprot   <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
    end else begin
      init_q   <= init;
      txn_done <= 1'b0;
      if (timeout) begin
        error    <= 1'b1;
        awvalid  <= 1'b0;
        wvalid   <= 1'b0;
        bready   <= 1'b0;
        arvalid  <= 1'b0;
        rready   <= 1'b0;
        wcnt     <= '0;
        rcnt     <= '0;
        txn_done <= 1'b1;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              error   <= 1'b0;
              wcnt    <= '0;
              rcnt    <= '0;
              awaddr  <= word_addr(CW'(0));
              wdata   <= word_data(CW'(0));
              wstrb   <= 4'hF;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_ADDR_DATA;
            end
          end
          WR_ADDR_DATA: begin
            if (aw_hs) awvalid <= 1'b0;
            if (w_hs)  wvalid  <= 1'b0;
            if (aw_fin && w_fin) begin
              bready <= 1'b1;
              state  <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (b_hs) begin
              bready <= 1'b0;
              if (bresp != 2'b00) error <= 1'b1;
              wcnt <= wcnt_nxt;
              if (last_w) begin
                araddr  <= word_addr(CW'(0));
                arvalid <= 1'b1;
                state   <= RD_ADDR;
              end else begin
                awaddr  <= word_addr(wcnt_nxt);
                wdata   <= word_data(wcnt_nxt);
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                state   <= WR_ADDR_DATA;
              end
            end
          end
          RD_ADDR: begin
            if (ar_hs) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (r_hs) begin
              rready <= 1'b0;
              if (rdata != word_data(rcnt) || rresp != 2'b00) error <= 1'b1;
              rcnt <= rcnt_nxt;
              if (last_r) begin
                txn_done <= 1'b1;
                state    <= DONE;
              end else begin
                araddr  <= word_addr(rcnt_nxt);
                arvalid <= 1'b1;
                state   <= RD_ADDR;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
